// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
// Purpose : shared definitions for the next-PC / instruction-fetch sequencer.
// Contents: FSM state encoding, PC increment step and the NOP instruction
//           used as the reset value of the instruction holding register.
package pc_sequencer_pkg;

    // Sequencer states; the explicit values are the documented encoding
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } seqState_e;

    // Sequential fetch advances by one 32-bit instruction
    localparam int PC_INC = 4;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_sequencer_register.sv
// Register
// Purpose : generic N-bit register with load enable and asynchronous,
//           active-low reset to a parameterised value.
// Ports   : clk    - rising-edge clock
//           rst_n  - asynchronous reset, active low
//           i_ld   - load enable; o_q takes i_d on the next edge when high
//           i_d    - data in (N bits)
//           o_q    - registered data out (N bits)
module Register #(
    parameter int           N         = 32,
    parameter logic [N-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_ld,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);

    // Hold the value unless a load is requested; reset wins asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= RESET_VAL;
        end else if (i_ld) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Purpose : next-PC and instruction-fetch sequencer sitting in front of the
//           PC register. Drives the PC register load/D, runs a req/gnt/rvalid
//           handshake with a variable-latency instruction memory, hands the
//           fetched instruction to decode over valid/ready and applies
//           execute redirects, including while a fetch is outstanding.
// Ports   : clk, rst                   - clock, async active-low reset
//           pc_q                       - PC register Q (current PC)
//           pc_ld, pc_d                - PC register load enable and D
//           imem_req, imem_addr        - fetch request and address
//           imem_gnt                   - request accepted this cycle
//           imem_rvalid, imem_rdata    - fetch response
//           redirect_valid/_pc         - taken branch/jump from execute
//           instr_valid, instr_ready   - decode handshake
//           instr, instr_pc            - held instruction and its PC
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_q,
    output logic            pc_ld,
    output logic [XLEN-1:0] pc_d,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    // Clears the two address LSBs so every PC written is word aligned
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    seqState_e       r_state;
    seqState_e       w_nextState;
    logic            r_kill;
    logic            w_killNext;
    logic            w_pcLd;
    logic            w_imemReq;
    logic            w_instrLd;
    logic            w_instrPcLd;
    logic [XLEN-1:0] w_pcNext;

    // State and kill flag. Kill marks an outstanding fetch whose response
    // must be thrown away because a redirect arrived while it was in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= BOOT;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_kill  <= w_killNext;
        end
    end

    // Next-state and combinational outputs. A redirect always takes
    // priority over the grant, the response and the decode handshake.
    always_comb begin
        w_nextState = r_state;
        w_killNext  = r_kill;
        w_pcLd      = 1'b0;
        w_pcNext    = pc_q;
        w_imemReq   = 1'b0;
        w_instrLd   = 1'b0;
        w_instrPcLd = 1'b0;
        unique case (r_state)
            BOOT: begin
                w_pcLd      = 1'b1;
                w_pcNext    = RESET_PC;
                w_nextState = REQ;
            end
            REQ: begin
                if (redirect_valid) begin
                    w_pcLd   = 1'b1;
                    w_pcNext = redirect_pc;
                end else begin
                    w_imemReq = 1'b1;
                    if (imem_gnt) begin
                        w_instrPcLd = 1'b1;
                        w_nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    w_pcLd   = 1'b1;
                    w_pcNext = redirect_pc;
                end
                // The memory cannot cancel a request, so a stale fetch is
                // drained here before the redirected fetch is issued.
                if (imem_rvalid) begin
                    if (r_kill || redirect_valid) begin
                        w_killNext  = 1'b0;
                        w_nextState = REQ;
                    end else begin
                        w_instrLd   = 1'b1;
                        w_nextState = HOLD;
                    end
                end else if (redirect_valid) begin
                    w_killNext = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    w_pcLd      = 1'b1;
                    w_pcNext    = redirect_pc;
                    w_nextState = REQ;
                end else if (instr_ready) begin
                    w_pcLd      = 1'b1;
                    w_pcNext    = pc_q + XLEN'(PC_INC);
                    w_nextState = REQ;
                end
            end
            default: begin
                w_nextState = BOOT;
            end
        endcase
    end

    // Reset is asynchronous, so the combinational strobes are gated by it
    // to keep the PC register and memory quiet while reset is asserted.
    assign pc_ld       = rst & w_pcLd;
    assign imem_req    = rst & w_imemReq;
    assign pc_d        = w_pcNext & ALIGN_MASK;
    assign imem_addr   = pc_q;
    assign instr_valid = (r_state == HOLD);

    Register #(
        .N         (ILEN),
        .RESET_VAL (ILEN'(NOP_INSTR))
    ) u_instrReg (
        .clk   (clk),
        .rst_n (rst),
        .i_ld  (w_instrLd),
        .i_d   (imem_rdata),
        .o_q   (instr)
    );

    Register #(
        .N         (XLEN),
        .RESET_VAL ('0)
    ) u_instrPcReg (
        .clk   (clk),
        .rst_n (rst),
        .i_ld  (w_instrPcLd),
        .i_d   (pc_q),
        .o_q   (instr_pc)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Purpose : randomized scoreboard bench for pc_sequencer. Plays the PC
//           register, the instruction memory, execute and decode. A fetch
//           level reference model predicts requests, PC loads and which
//           fetched instructions must reach decode.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_1000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcReg;
    logic        pc_ld;
    logic [31:0] pc_d;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int checkCount = 0;
    int errorCount = 0;
    int presented  = 0;

    // Reference model: what has been fetched, what is held for decode
    fetch_t      sbQueue[$];
    bit          bootCycle;
    bit          held;
    bit          inFlight;
    bit          poisoned;
    bit          firstRsp;
    logic [31:0] heldPc;
    logic [31:0] flightPc;
    logic [31:0] nextFetchPc;
    int          gntWait;
    int          rspWait;

    pc_sequencer #(
        .XLEN     (32),
        .ILEN     (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_q           (pcReg),
        .pc_ld          (pc_ld),
        .pc_d           (pc_d),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // The PC register the sequencer drives
    always @(posedge clk or negedge rst) begin
        if (!rst) pcReg <= 32'h0;
        else if (pc_ld) pcReg <= pc_d;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] pickTarget();
        logic [31:0] t;
        case ($urandom_range(0, 4))
            0:       t = 32'h0000_2000;
            1:       t = 32'h0000_3002;
            2:       t = 32'hFFFF_FFFC;
            3:       t = 32'hFFFF_FFF8;
            default: t = $urandom;
        endcase
        return t;
    endfunction

    // Assert reset, check the immediate outputs, release on a negedge
    task automatic applyReset();
        rst            = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        #1;
        checkOutput("reset_instr_valid", instr_valid, 0);
        checkOutput("reset_imem_req", imem_req, 0);
        checkOutput("reset_pc_ld", pc_ld, 0);
        checkOutput("reset_instr", instr, NOP);
        checkOutput("reset_instr_pc", instr_pc, 0);
        repeat (2) @(negedge clk);
        sbQueue.delete();
        bootCycle   = 1'b1;
        held        = 1'b0;
        inFlight    = 1'b0;
        poisoned    = 1'b0;
        nextFetchPc = RESET_PC;
        gntWait     = 0;
        rspWait     = 0;
        rst         = 1'b1;
    endtask

    // One cycle: drive random inputs, check outputs against the model,
    // advance the model, then move to the next negedge
    task automatic applyStimulus(input bit allowRedirect);
        bit          redir, rv, consume, gnt, reqState, expReq, expLd;
        logic [31:0] expD, rdata;
        redir          = allowRedirect && !bootCycle && ($urandom_range(0, 7) == 0);
        redirect_valid = redir;
        redirect_pc    = pickTarget();
        instr_ready    = ($urandom_range(0, 2) != 0);
        rv             = inFlight && (rspWait == 0);
        imem_rvalid    = rv || (!inFlight && ($urandom_range(0, 3) == 0));
        rdata          = firstRsp ? 32'h0050_0093 : $urandom;
        imem_rdata     = rdata;
        reqState       = !bootCycle && !held && !inFlight;
        expReq         = reqState && !redir;
        gnt            = expReq && (gntWait == 0);
        imem_gnt       = gnt || (reqState && redir && ($urandom_range(0, 1) == 1));
        #1;
        consume = held && instr_ready && !redir;
        expLd   = bootCycle || redir || consume;
        checkOutput("imem_req", imem_req, expReq);
        if (expReq) checkOutput("imem_addr", imem_addr, nextFetchPc);
        checkOutput("instr_valid", instr_valid, held);
        checkOutput("pc_ld", pc_ld, expLd);
        if (expLd) begin
            if (bootCycle) expD = RESET_PC;
            else if (redir) expD = redirect_pc & ~32'd3;
            else expD = heldPc + 32'd4;
            checkOutput("pc_d", pc_d, expD);
        end
        if (bootCycle) begin
            bootCycle   = 1'b0;
            nextFetchPc = RESET_PC;
        end else if (redir) begin
            nextFetchPc = redirect_pc & ~32'd3;
            held        = 1'b0;
            if (rv) inFlight = 1'b0;
            else if (inFlight) begin
                poisoned = 1'b1;
                rspWait--;
            end
        end else begin
            if (consume) begin
                held        = 1'b0;
                nextFetchPc = heldPc + 32'd4;
            end
            if (rv) begin
                inFlight = 1'b0;
                if (!poisoned) begin
                    held   = 1'b1;
                    heldPc = flightPc;
                    sbQueue.push_back({flightPc, rdata});
                    firstRsp = 1'b0;
                end
            end else if (inFlight) begin
                rspWait--;
            end
            if (gnt) begin
                inFlight = 1'b1;
                poisoned = 1'b0;
                flightPc = nextFetchPc;
                rspWait  = $urandom_range(0, 2);
                gntWait  = $urandom_range(0, 3);
            end else if (expReq) begin
                gntWait--;
            end
        end
        @(negedge clk);
    endtask

    // Monitor: every new presentation to decode must match the next
    // instruction the model expects
    initial begin
        bit     prevValid;
        fetch_t item;
        prevValid = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst !== 1'b1) begin
                prevValid = 1'b0;
            end else begin
                if (instr_valid === 1'b1 && !prevValid) begin
                    presented++;
                    if (sbQueue.size() == 0) begin
                        checkCount++;
                        errorCount++;
                        $display("[TB] FAIL unexpected_instr: got instr %h pc %h, expected none at %0t", instr, instr_pc, $time);
                    end else begin
                        item = sbQueue.pop_front();
                        checkOutput("instr", instr, item.data);
                        checkOutput("instr_pc", instr_pc, item.pc);
                    end
                end
                prevValid = (instr_valid === 1'b1);
            end
        end
    end

    // Main sequence: reset, random traffic, mid-fetch reset, more traffic
    initial begin
        firstRsp = 1'b1;
        rst      = 1'b1;
        #1;
        applyReset();
        for (int i = 0; i < 1500; i++) applyStimulus(1'b1);
        for (int k = 0; k < 20 && !inFlight; k++) applyStimulus(1'b1);
        checkOutput("reset_setup_inflight", inFlight, 1);
        applyReset();
        for (int i = 0; i < 1500; i++) applyStimulus(1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0);
        #3;
        checkOutput("scoreboard_drained", sbQueue.size(), 0);
        checkCount++;
        if (presented < 20) begin
            errorCount++;
            $display("[TB] FAIL liveness: got %0d presentations, expected at least 20", presented);
        end
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC and instruction-fetch sequencer directly upstream of the PC register: drives the PC register's ld and D inputs and reads its Q output back.
- Runs a request/grant/response handshake with a variable-latency instruction memory.
- Presents the fetched instruction and its PC to decode through a valid/ready handshake.
- Applies branch/jump redirects from execute, including while a fetch is in flight.

Parameters:
- XLEN, 32, width of PC and addresses.
- ILEN, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- pc_q  in  XLEN  current PC from the PC register Q.
- pc_ld  out  1  PC register load enable.
- pc_d  out  XLEN  PC register D (next PC).
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  ILEN  response instruction.
- redirect_valid  in  1  branch/jump taken, from execute.
- redirect_pc  in  XLEN  redirect target.
- instr_valid  out  1  instruction available to decode.
- instr_ready  in  1  decode accepts the instruction.
- instr  out  ILEN  held instruction.
- instr_pc  out  XLEN  PC of the held instruction.

Behaviour:
- Reset (rst=0, asynchronous): state=BOOT, kill=0, instr=32'h0000_0013 (NOP), instr_pc=0.
- During reset: instr_valid=0, imem_req=0, pc_ld=0.
- FSM states: BOOT, REQ, WAIT, HOLD. All outputs other than pc_d, pc_ld, imem_req and imem_addr are registered.
- BOOT:
  - pc_ld=1, pc_d=RESET_PC.
  - Next state is REQ unconditionally.
  - redirect_valid is ignored.
- REQ:
  - Default: imem_req=1, imem_addr=pc_q.
  - imem_gnt=1: capture instr_pc<=pc_q, go to WAIT.
  - redirect_valid=1: has priority. imem_req=0 that cycle (imem_gnt is ignored), pc_ld=1, pc_d=redirect_pc, stay in REQ.
- WAIT:
  - imem_req=0.
  - redirect_valid=1: pc_ld=1, pc_d=redirect_pc, kill<=1.
  - imem_rvalid=1 with kill=0 and no redirect this cycle: instr<=imem_rdata, go to HOLD.
  - imem_rvalid=1 with kill=1, or with a redirect in the same cycle: discard data, kill<=0, go to REQ.
- HOLD:
  - instr_valid=1.
  - instr_ready=1: pc_ld=1, pc_d=pc_q+4, go to REQ.
  - redirect_valid=1: drop the held instruction, pc_ld=1, pc_d=redirect_pc, go to REQ.
  - redirect_valid and instr_ready in the same cycle: redirect wins and the instruction is not counted as consumed.
- Latency: minimum 3 cycles from entering REQ to instr_valid (grant cycle, response cycle, HOLD). instr_valid stays 1 until consumed or flushed.
- pc_d alignment: pc_d[1:0] is always forced to 2'b00, so a misaligned redirect is truncated.
- Increment wrap-around: pc_q=32'hFFFF_FFFC gives pc_d=32'h0000_0000, no flag.
- imem_rvalid outside WAIT is ignored.
- pc_ld=0 in every case not listed above.
- Reset mid-fetch returns to BOOT, any later response is ignored, and RESET_PC is reloaded.

Decomposition:
- Shared processor package holds:
  - state encoding localparams (BOOT=2'd0, REQ=2'd1, WAIT=2'd2, HOLD=2'd3);
  - PC_INC=4;
  - NOP_INSTR=32'h0000_0013.
- The instr/instr_pc holding registers use the existing N-bit load-enable Register module (N=ILEN and N=XLEN).
- No other sub-module.

Test Plan:
- Reset release, RESET_PC=32'h0000_1000, memory grants at once and responds 1 cycle later with 32'h0050_0093 -> cycle 0 pc_ld=1 with pc_d=32'h1000; imem_addr=32'h1000; instr_valid with instr=32'h0050_0093 and instr_pc=32'h1000; on instr_ready, pc_d=32'h1004.
- Grant delayed 3 cycles, then response delayed 2 -> imem_req stays 1 with a stable imem_addr until imem_gnt; instr_valid rises 1 cycle after imem_rvalid.
- redirect_valid with redirect_pc=32'h2000 during WAIT, then imem_rvalid -> data discarded, instr_valid stays 0, next imem_addr=32'h2000.
- HOLD with instr_ready=1 and redirect_valid=1 (redirect_pc=32'h3002) in the same cycle -> pc_d=32'h3000, the held instruction is dropped, next fetch at 32'h3000.
- pc_q=32'hFFFF_FFFC consumed in HOLD -> pc_d=32'h0000_0000; rst pulsed low in WAIT -> instr_valid=0 and instr=NOP immediately, BOOT on release.
